// File: rtl/wb_cmd_master_if.sv
// Command/response stream and Wishbone bus bundle for wb_cmd_master.
// The master modport is the initiator's view; slave is the view of the
// user logic and the Wishbone target that sit on the other side.
interface wb_cmd_master_if;
  // Command stream from user logic
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  // Response stream back to user logic
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  // Wishbone classic master port
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  rsp_ready_i,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o,
    output rsp_ready_i,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic (non-pipelined) initiator: one command in, one single
// read/write cycle on the bus, one response out; one transaction in flight.
// Optional watchdog: define WB_CMD_MASTER_TIMEOUT_EN to abort cycles that
// stay un-acked for 2^TO_W - 1 bus cycles and report them with rsp_err_o.
// Without the macro the bus phase waits for ack forever and rsp_err_o is 0.
module wb_cmd_master #(
  parameter int TO_W = 8
) (
  input  logic wb_clk_i,
  input  logic wb_rst_n_i,
  wb_cmd_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        cmd_ready;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        rsp_valid;
  logic [31:0] rsp_dat;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  // Last count value before the abort: the cycle that would make the
  // un-acked count reach 2^TO_W - 1 is the one that times out.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((2 ** TO_W) - 2);

  logic [TO_W-1:0] to_cnt;
  logic            rsp_err;

  assign bus.rsp_err_o = rsp_err;
`else
  // Width parameter kept for a common instantiation; no counter exists.
  logic unused_to_w;

  assign unused_to_w   = (TO_W != 0);
  assign bus.rsp_err_o = 1'b0;
`endif

  assign bus.cmd_ready_o = cmd_ready;
  assign bus.wbm_cyc_o   = cyc;
  assign bus.wbm_stb_o   = stb;
  assign bus.wbm_we_o    = we;
  assign bus.wbm_adr_o   = adr;
  assign bus.wbm_dat_o   = wdat;
  assign bus.wbm_sel_o   = sel;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_dat_o   = rsp_dat;

  // Transaction FSM with every output registered; ready depends only on state.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      cyc       <= 1'b0;
      stb       <= 1'b0;
      we        <= 1'b0;
      adr       <= '0;
      wdat      <= '0;
      sel       <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      rsp_err   <= 1'b0;
      to_cnt    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid_i && cmd_ready) begin
            we        <= bus.cmd_we_i;
            adr       <= bus.cmd_adr_i;
            wdat      <= bus.cmd_dat_i;
            sel       <= bus.cmd_sel_i;
            cyc       <= 1'b1;
            stb       <= 1'b1;
            cmd_ready <= 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            to_cnt    <= '0;
`endif
            state     <= BUS;
          end
        end
        BUS: begin
          // Ack has priority over a watchdog expiry in the same cycle.
          if (bus.wbm_ack_i) begin
            cyc       <= 1'b0;
            stb       <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_dat   <= we ? 32'h0 : bus.wbm_dat_i;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= RESP;
          end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            cyc       <= 1'b0;
            stb       <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_dat   <= 32'h0;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          cyc       <= 1'b0;
          stb       <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic (B4, non-pipelined) initiator for the user project area. It turns a valid/ready command stream from user logic into single Wishbone read or write cycles and returns each result on a valid/ready response stream. Only one transaction is in flight at a time, and an optional watchdog terminates cycles that are never acknowledged. It is the master-side counterpart of the Wishbone slave port the wrapper presents to the management SoC, and it drives user-area peripherals from user logic.

## Interface

Parameters:
- `TO_W`, default 8: width of the timeout counter; a cycle aborts after 2^TO_W − 1 un-acked cycles.

Ports:
- `wb_clk_i`  in  1  sole clock; all logic is on the rising edge.
- `wb_rst_n_i`  in  1  reset, **synchronous, active-low**.
- `cmd_valid_i`  in  1  a command is presented.
- `cmd_ready_o`  out  1  the block accepts a command this cycle.
- `cmd_we_i`  in  1  1 = write, 0 = read.
- `cmd_adr_i`  in  32  byte address.
- `cmd_dat_i`  in  32  write data.
- `cmd_sel_i`  in  4  byte lane selects.
- `rsp_valid_o`  out  1  a response is presented.
- `rsp_ready_i`  in  1  the consumer takes the response.
- `rsp_dat_o`  out  32  read data; 0 for writes and for errors.
- `rsp_err_o`  out  1  the cycle timed out.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each  Wishbone control.
- `wbm_adr_o`  out  32  Wishbone address.
- `wbm_dat_o`  out  32  Wishbone write data.
- `wbm_sel_o`  out  4  Wishbone byte selects.
- `wbm_dat_i`  in  32  Wishbone read data.
- `wbm_ack_i`  in  1  Wishbone acknowledge.

## Operation

- **FSM states:** IDLE, BUS, RESP. Reset state is IDLE.
- **IDLE**
  - `cmd_ready_o` = 1; it is decoded from the registered state only, with no combinational path from `cmd_valid_i`.
  - On `cmd_valid_i & cmd_ready_o`: register we/adr/dat/sel into the `wbm_*` outputs, set `wbm_cyc_o` = `wbm_stb_o` = 1, clear the timeout counter, and go to BUS.
- **BUS**
  - `cmd_ready_o` = 0. `wbm_*` outputs are held stable.
  - The counter increments every cycle without ack.
  - **`wbm_ack_i` = 1:**
    - Clear `cyc`/`stb` at that edge.
    - Load `rsp_dat_o` = `wbm_dat_i` for a read, 0 for a write; `rsp_err_o` = 0.
    - Go to RESP.
  - **Counter reaches 2^TO_W − 1 with no ack:**
    - Clear `cyc`/`stb`.
    - `rsp_dat_o` = 0, `rsp_err_o` = 1.
    - Go to RESP.
  - Ack and timeout in the same cycle: ack wins and the response is normal.
  - `wbm_ack_i` outside BUS is ignored.
- **RESP**
  - `rsp_valid_o` = 1, with `rsp_dat_o`/`rsp_err_o` held until `rsp_valid_o & rsp_ready_i`, then go to IDLE.
  - `cmd_ready_o` stays 0 throughout RESP.
- **Reset**
  - Reset in any state, including mid-cycle, forces IDLE at the next edge.
  - Every output resets to 0, except that `cmd_ready_o` is 1 from the first cycle after reset.
  - A transaction in flight is dropped with no response.
- `wbm_adr_o` is passed through unaltered; there is no alignment check.

## Timing

- Command accepted at edge N: `cyc`/`stb` are high from N+1.
- Ack sampled at edge M (M ≥ N+1): `cyc`/`stb` are low and `rsp_valid_o` is high from M+1.
- Minimum command-to-response latency is 2 cycles (ack in the first BUS cycle).
- The response handshake completes at edge R, giving IDLE from R+1. The next command can be accepted at R+1, so the best-case throughput is one transaction per 3 cycles.
- Timeout: with `cyc` first high at cycle N+1 and no ack, `cyc` is dropped and an error response is raised after 2^TO_W − 1 BUS cycles. For TO_W = 8 this is 255 cycles.
- `rsp_ready_i` low in RESP stalls indefinitely. No Wishbone signal is asserted during the stall.

## Configuration

- Macro: `WB_CMD_MASTER_TIMEOUT_EN`.
- **Defined:** the timeout counter and the error path are built as described above.
- **Undefined:**
  - No counter is built; BUS waits indefinitely for `wbm_ack_i`.
  - `rsp_err_o` is tied to 0.
  - `TO_W` is accepted but unused.

## Test plan

- **Single write.**
  - Stimulus: cmd we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF; ack in the 2nd BUS cycle.
  - Required: the `wbm_*` fields match the command; cyc/stb are high for exactly 2 cycles; rsp_valid with dat=0, err=0.
- **Single read.**
  - Stimulus: cmd we=0, adr=0x3000_0010, sel=0x3; slave acks immediately with `wbm_dat_i`=0x1234_5678.
  - Required: cyc is high for 1 cycle; rsp_dat=0x1234_5678 two cycles after cmd acceptance.
- **Backpressure.**
  - Stimulus: `rsp_ready_i` held low for 10 cycles after a read completes, while a second command waits on `cmd_valid_i`.
  - Required: the response is held stable; `cmd_ready_o` = 0 throughout; the second command is accepted the cycle after the handshake.
- **Timeout (macro defined, TO_W = 4).**
  - Stimulus: a read that is never acked.
  - Required: cyc drops after 15 BUS cycles; rsp_err=1, rsp_dat=0.
  - Follow-up: a subsequent acked write completes normally with err=0.
- **Ack and timeout coincide (TO_W = 4).**
  - Stimulus: ack on the 15th BUS cycle with `wbm_dat_i`=0xA5A5_A5A5.
  - Required: err=0, dat=0xA5A5_A5A5.
  - Macro undefined: an ack after 1000 cycles completes normally and `rsp_err_o` never asserts.
- **Reset mid-cycle.**
  - Stimulus: `wb_rst_n_i` low for 1 cycle while in BUS.
  - Required: at the next edge cyc/stb/rsp_valid=0 and `cmd_ready_o`=1; no response is ever issued for the dropped command; a late ack is ignored.
